// File: rtl/medidor_pkg.sv
// Shared types and constants for the ultrasonic ranging front end and the
// downstream distance discretiser.
package medidor_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIGGER   = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4
    } estado_t;

    typedef logic [3:0]        bcd_digit_t;
    typedef bcd_digit_t [2:0]  bcd3_t;      // [2] hundreds, [1] tens, [0] units

    localparam bcd3_t BCD_SAT = 12'h999;

    // Decimal increment that sticks at 999 instead of wrapping.
    function automatic bcd3_t bcd_inc(input bcd3_t v);
        bcd3_t r;
        r = v;
        if (v != BCD_SAT) begin
            if (v[0] != 4'd9) begin
                r[0] = v[0] + 4'd1;
            end else begin
                r[0] = 4'd0;
                if (v[1] != 4'd9) begin
                    r[1] = v[1] + 4'd1;
                end else begin
                    r[1] = 4'd0;
                    r[2] = v[2] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit BCD up-counter with synchronous clear; saturates at 999.
module contador_bcd_3dig
    import medidor_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  zera,
    input  logic  conta,
    output bcd3_t valor,
    output logic  max
);

    bcd3_t r_valor;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valor <= '0;
        end else if (zera) begin
            r_valor <= '0;
        end else if (conta) begin
            r_valor <= bcd_inc(r_valor);
        end
    end

    assign valor = r_valor;
    assign max   = (r_valor == BCD_SAT);

endmodule

// File: rtl/medidor_distancia.sv
// Ultrasonic ranging front end: fires the trigger, times the echo and reports
// the distance in whole centimetres as 3-digit BCD with a one-cycle strobe.
module medidor_distancia
    import medidor_pkg::*;
#(
    parameter int TRIG_CYCLES  = 500,
    parameter int TICKS_PER_CM = 2941,
    parameter int ECHO_TIMEOUT = 1_500_000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [2:0]  db_estado
);

    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
    localparam int TICK_W = $clog2(TICKS_PER_CM + 1);
    localparam int TMO_W  = $clog2(ECHO_TIMEOUT + 1);

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_CM - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ECHO_TIMEOUT - 1);

    estado_t           r_estado;
    logic [TRIG_W-1:0] r_trig_cnt;
    logic [TICK_W-1:0] r_tick;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_trigger;
    logic [11:0]       r_medida;
    logic              r_pronto;
    logic              r_erro;

    logic              r_echo_s1;
    logic              r_echo_s2;
    logic              r_echo_d;

    logic              w_sobe;
    logic              w_desce;
    logic              w_round;
    logic              w_wrap;
    logic              w_zera;
    logic              w_conta;
    logic              w_max;
    bcd3_t             w_bcd;
    bcd3_t             w_bcd_final;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_d  <= 1'b0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    assign w_sobe  =  r_echo_s2 & ~r_echo_d;
    assign w_desce = ~r_echo_s2 &  r_echo_d;

    // The rising-edge cycle is not in the tick count, so the fall cycle is tick+1.
    assign w_round = (32'(r_tick) + 32'd1) >= 32'(TICKS_PER_CM / 2);

    assign w_wrap  = (r_estado == MEASURE) && !w_desce && (r_tick == TICK_LAST);
    assign w_zera  = (r_estado == IDLE) && medir;
    assign w_conta = w_wrap || ((r_estado == MEASURE) && w_desce && w_round && !w_max);

    assign w_bcd_final = w_round ? bcd_inc(w_bcd) : w_bcd;

    contador_bcd_3dig u_contador (
        .clk   (clk),
        .reset (reset),
        .zera  (w_zera),
        .conta (w_conta),
        .valor (w_bcd),
        .max   (w_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado   <= IDLE;
            r_trig_cnt <= '0;
            r_tick     <= '0;
            r_tmo      <= '0;
            r_trigger  <= 1'b0;
            r_medida   <= 12'h000;
            r_pronto   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                IDLE: begin
                    if (medir) begin
                        r_estado   <= TRIGGER;
                        r_trig_cnt <= '0;
                        r_tick     <= '0;
                    end
                end
                TRIGGER: begin
                    if (r_trig_cnt == TRIG_LAST) begin
                        r_trigger <= 1'b0;
                        r_tmo     <= '0;
                        r_estado  <= WAIT_ECHO;
                    end else begin
                        r_trigger  <= 1'b1;
                        r_trig_cnt <= r_trig_cnt + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    if (w_sobe) begin
                        r_tick   <= '0;
                        r_estado <= MEASURE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_medida <= BCD_SAT;
                        r_erro   <= 1'b1;
                        r_pronto <= 1'b1;
                        r_estado <= DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                MEASURE: begin
                    // Outputs are loaded on entry to DONE so pronto is high in the DONE cycle.
                    if (w_max) begin
                        r_medida <= BCD_SAT;
                        r_erro   <= 1'b1;
                        r_pronto <= 1'b1;
                        r_estado <= DONE;
                    end else if (w_desce) begin
                        r_medida <= w_bcd_final;
                        r_erro   <= (w_bcd_final == BCD_SAT);
                        r_pronto <= 1'b1;
                        r_estado <= DONE;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                DONE: begin
                    r_estado <= IDLE;
                end
                default: begin
                    r_estado <= IDLE;
                end
            endcase
        end
    end

    assign trigger   = r_trigger;
    assign medida    = r_medida;
    assign pronto    = r_pronto;
    assign erro      = r_erro;
    assign db_estado = r_estado;

endmodule
